// File: rtl/cmos_demux_reg.sv
// Registered 1-to-N demultiplexer with a valid/ready handshake and a sticky protocol-error flag.
// Optional broadcast mode (all channels, retired once every channel accepts) is enabled by DEMUX_BROADCAST_EN.
module cmos_demux_reg #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             d,
    input  logic [SEL_W-1:0]              s,
`ifdef DEMUX_BROADCAST_EN
    input  logic                          bcast,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [(2**SEL_W)*DATA_W-1:0]  y,
    output logic [(2**SEL_W)-1:0]         y_valid,
    input  logic [(2**SEL_W)-1:0]         y_ready,
    output logic                          err
);

    localparam int N_OUT = 2**SEL_W;

    typedef enum logic {IDLE, FULL} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   buf_q;
    logic [SEL_W-1:0]    sel_q;
    logic                ready_c;
    logic                xfer;
    logic                load;

    // Snapshot of the source's offer during a stall, used to detect hold-rule violations.
    logic                stall_q;
    logic [DATA_W-1:0]   hold_d_q;
    logic [SEL_W-1:0]    hold_s_q;
    logic                violation;

`ifdef DEMUX_BROADCAST_EN
    logic                bcast_q;
    logic [N_OUT-1:0]    done_q;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        xfer    = 1'b0;
        y       = '0;
        y_valid = '0;
        unique case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (in_valid) state_d = FULL;
            end
            FULL: begin
`ifdef DEMUX_BROADCAST_EN
                if (bcast_q) begin
                    y_valid = ~done_q;
                    for (int i = 0; i < N_OUT; i++) y[i*DATA_W +: DATA_W] = buf_q;
                    xfer = &(done_q | y_ready);
                end else begin
`endif
                    for (int i = 0; i < N_OUT; i++) begin
                        if (sel_q == SEL_W'(i)) begin
                            y_valid[i]             = 1'b1;
                            y[i*DATA_W +: DATA_W]  = buf_q;
                        end
                    end
                    xfer = y_ready[sel_q];
`ifdef DEMUX_BROADCAST_EN
                end
`endif
                ready_c = xfer;
                if (xfer && !in_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = ready_c & ~rst;
    assign load      = in_valid & in_ready;
    // A stalled offer must stay valid with unchanged d/s until it is accepted.
    assign violation = stall_q & (!in_valid || (d != hold_d_q) || (s != hold_s_q));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            sel_q    <= '0;
            err      <= 1'b0;
            stall_q  <= 1'b0;
            hold_d_q <= '0;
            hold_s_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                buf_q <= d;
                sel_q <= s;
            end
            err     <= err | violation;
            stall_q <= in_valid & ~in_ready;
            if (in_valid && !in_ready) begin
                hold_d_q <= d;
                hold_s_q <= s;
            end
        end
    end

`ifdef DEMUX_BROADCAST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcast_q <= 1'b0;
            done_q  <= '0;
        end else begin
            if (load) bcast_q <= bcast;
            if (xfer || state_q != FULL || !bcast_q) done_q <= '0;
            else                                    done_q <= done_q | y_ready;
        end
    end
`endif

endmodule

// File: tb/tb_cmos_demux_reg.sv
// Directed self-checking bench for cmos_demux_reg (DATA_W=8, SEL_W=1).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_cmos_demux_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d;
    logic [0:0]  s;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y;
    logic [1:0]  y_valid;
    logic [1:0]  y_ready;
    logic        err;
`ifdef DEMUX_BROADCAST_EN
    logic        bcast = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    cmos_demux_reg #(.DATA_W(8), .SEL_W(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .s        (s),
`ifdef DEMUX_BROADCAST_EN
        .bcast    (bcast),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; d = '0; s = '0; in_valid = 1'b0; y_ready = 2'b00;
        do_reset();
        check("reset_y_valid", 32'(y_valid), 32'h0);
        check("reset_y", 32'(y), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        check("reset_err", 32'(err), 32'h0);

        // Single unicast to ch1.
        tick();
        d = 8'h3C; s = 1'b1; in_valid = 1'b1; y_ready = 2'b11;
        #1 check("uni_in_ready_idle", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        #1;
        check("uni_y_valid", 32'(y_valid), 32'h2);
        check("uni_y", 32'(y), 32'h3C00);
        check("uni_in_ready_pass", 32'(in_ready), 32'h1);
        tick();
        check("uni_idle_y_valid", 32'(y_valid), 32'h0);
        check("uni_idle_y", 32'(y), 32'h0);

        // Backpressure on ch0; d goes to X once the word is accepted.
        d = 8'h55; s = 1'b0; in_valid = 1'b1; y_ready = 2'b10;
        tick();
        in_valid = 1'b0; d = 'x;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_y_valid", 32'(y_valid), 32'h1);
            check("bp_y", 32'(y), 32'h0055);
            check("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
        end
        y_ready = 2'b11;
        #1 check("bp_release_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("bp_retired", 32'(y_valid), 32'h0);
        check("bp_err_clean", 32'(err), 32'h0);
        d = '0;

        // Back-to-back stream on alternating channels.
        d = 8'h01; s = 1'b0; in_valid = 1'b1; y_ready = 2'b11;
        #1 check("b2b_rdy0", 32'(in_ready), 32'h1);
        tick();
        check("b2b_v1", 32'(y_valid), 32'h1);
        check("b2b_y1", 32'(y), 32'h0001);
        d = 8'h02; s = 1'b1;
        #1 check("b2b_rdy1", 32'(in_ready), 32'h1);
        tick();
        check("b2b_v2", 32'(y_valid), 32'h2);
        check("b2b_y2", 32'(y), 32'h0200);
        d = 8'h03; s = 1'b0;
        #1 check("b2b_rdy2", 32'(in_ready), 32'h1);
        tick();
        check("b2b_v3", 32'(y_valid), 32'h1);
        check("b2b_y3", 32'(y), 32'h0003);
        in_valid = 1'b0;
        tick();
        check("b2b_drain", 32'(y_valid), 32'h0);
        check("b2b_err_clean", 32'(err), 32'h0);

        // Protocol error: stalled offer changes d while still valid.
        d = 8'h10; s = 1'b0; in_valid = 1'b1; y_ready = 2'b00;
        tick();
        check("perr_stall_rdy", 32'(in_ready), 32'h0);
        check("perr_y", 32'(y), 32'h0010);
        tick();
        check("perr_no_err_yet", 32'(err), 32'h0);
        d = 8'h11;
        tick();
        check("perr_err_set", 32'(err), 32'h1);
        check("perr_y_held", 32'(y), 32'h0010);
        in_valid = 1'b0;
        tick();
        tick();
        check("perr_sticky", 32'(err), 32'h1);

        // Async reset mid-FULL holding 8'hA5 on ch1.
        do_reset();
        check("perr_cleared", 32'(err), 32'h0);
        d = 8'hA5; s = 1'b1; in_valid = 1'b1; y_ready = 2'b00;
        tick();
        in_valid = 1'b0;
        #1;
        check("rst_pre_y_valid", 32'(y_valid), 32'h2);
        check("rst_pre_y", 32'(y), 32'hA500);
        #1 rst = 1'b1;
        #1;
        check("rst_async_y_valid", 32'(y_valid), 32'h0);
        check("rst_async_y", 32'(y), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_post_in_ready", 32'(in_ready), 32'h1);
        check("rst_post_err", 32'(err), 32'h0);

`ifdef DEMUX_BROADCAST_EN
        // Broadcast: ch0 accepts on cycle 1, ch1 on cycle 3.
        tick();
        d = 8'hF0; s = 1'b0; bcast = 1'b1; in_valid = 1'b1; y_ready = 2'b00;
        tick();
        in_valid = 1'b0; bcast = 1'b0;
        #1;
        check("bc_v0", 32'(y_valid), 32'h3);
        check("bc_y0", 32'(y), 32'hF0F0);
        check("bc_rdy0", 32'(in_ready), 32'h0);
        tick();
        y_ready = 2'b01;
        #1 check("bc_rdy1", 32'(in_ready), 32'h0);
        tick();
        y_ready = 2'b00;
        #1 check("bc_v1", 32'(y_valid), 32'h2);
        tick();
        y_ready = 2'b10;
        #1 check("bc_rdy3", 32'(in_ready), 32'h1);
        tick();
        y_ready = 2'b00;
        #1 check("bc_done", 32'(y_valid), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
